// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet controller slice.
// Contents: FSM state encoding, drop-cause codes, default start-of-packet
// marker and the running checksum helper.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LEN    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_COMMIT = 3'd5,
        ST_DONE   = 3'd6
    } pkt_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    // Packet checksum is a plain 8-bit modular sum of ADDR, LEN and payload.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store for one packet: DEPTH x 8 register array.
// Ports: clk, we/waddr/wdat synchronous write port, raddr/rdat
// asynchronous read port. Contents are intentionally not reset.
module uart_pkt_buf
    import uart_pkt_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdat,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdat
);

    logic [7:0] mem_r [DEPTH];

    // Capture one payload byte per write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdat;
        end
    end

    assign rdat = mem_r[raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind the UART receiver. Frames HDR, ADDR, LEN,
// payload, CSUM; verifies the checksum and only then commits the payload
// as a burst of register writes with a ready handshake.
// Ports: clk, rst (async, active-high), rx_dat/rx_rdy byte stream,
// wr_en/wr_addr/wr_dat/wr_rdy register write port, pkt_done/pkt_err
// pulses, err_code (cause of last drop), busy.
// Build option: define PKT_STAT_EN to add saturating good_cnt/bad_cnt.
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         TO_WIDTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_dat,
    input  logic       rx_rdy,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_dat,
    input  logic       wr_rdy,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
`ifdef PKT_STAT_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    localparam int                AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0]        MAX_LEN_9 = 9'(MAX_LEN);
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYC - 1);

    pkt_state_t          state_r;
    logic [7:0]          base_r;
    logic [AW-1:0]       last_r;     // len-1, index of the final payload byte
    logic [AW-1:0]       idx_r;
    logic [7:0]          acc_r;
    logic [TO_WIDTH-1:0] to_cnt_r;
    logic                wr_en_r;
    logic [7:0]          wr_addr_r;
    logic [7:0]          wr_dat_r;
    logic                pkt_done_r;
    logic                pkt_err_r;
    logic [1:0]          err_code_r;
    logic                busy_r;

    logic                buf_we_s;
    logic [AW-1:0]       buf_rd_idx_s;
    logic [7:0]          buf_rd_dat_s;
    logic [AW-1:0]       idx_nxt_s;

    assign idx_nxt_s = idx_r + AW'(1);
    assign buf_we_s  = (state_r == ST_DATA) && rx_rdy;

    // Read port looks one entry ahead during the burst so the next write
    // data is ready on acceptance; in CSUM it presents entry 0.
    always_comb begin
        buf_rd_idx_s = '0;
        if (state_r == ST_COMMIT) begin
            buf_rd_idx_s = idx_nxt_s;
        end else begin
            buf_rd_idx_s = '0;
        end
    end

    uart_pkt_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (buf_we_s),
        .waddr (idx_r),
        .wdat  (rx_dat),
        .raddr (buf_rd_idx_s),
        .rdat  (buf_rd_dat_s)
    );

    // Packet framing, checksum, timeout and commit FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            base_r     <= 8'd0;
            last_r     <= '0;
            idx_r      <= '0;
            acc_r      <= 8'd0;
            to_cnt_r   <= '0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= 8'd0;
            wr_dat_r   <= 8'd0;
            pkt_done_r <= 1'b0;
            pkt_err_r  <= 1'b0;
            err_code_r <= ERR_NONE;
            busy_r     <= 1'b0;
        end else begin
            pkt_done_r <= 1'b0;
            pkt_err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    to_cnt_r <= '0;
                    if (rx_rdy && (rx_dat == HDR_BYTE)) begin
                        state_r <= ST_ADDR;
                        busy_r  <= 1'b1;
                    end
                end
                ST_ADDR, ST_LEN, ST_DATA, ST_CSUM: begin
                    if (rx_rdy) begin
                        to_cnt_r <= '0;
                        case (state_r)
                            ST_ADDR: begin
                                base_r  <= rx_dat;
                                acc_r   <= rx_dat;
                                state_r <= ST_LEN;
                            end
                            ST_LEN: begin
                                if ((rx_dat == 8'd0) || ({1'b0, rx_dat} > MAX_LEN_9)) begin
                                    pkt_err_r  <= 1'b1;
                                    err_code_r <= ERR_LEN;
                                    state_r    <= ST_IDLE;
                                    busy_r     <= 1'b0;
                                end else begin
                                    last_r  <= AW'(rx_dat - 8'd1);
                                    idx_r   <= '0;
                                    acc_r   <= csum_add(acc_r, rx_dat);
                                    state_r <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                acc_r <= csum_add(acc_r, rx_dat);
                                if (idx_r == last_r) begin
                                    state_r <= ST_CSUM;
                                end else begin
                                    idx_r <= idx_nxt_s;
                                end
                            end
                            ST_CSUM: begin
                                if (rx_dat == acc_r) begin
                                    idx_r     <= '0;
                                    wr_en_r   <= 1'b1;
                                    wr_addr_r <= base_r;
                                    wr_dat_r  <= buf_rd_dat_s;
                                    state_r   <= ST_COMMIT;
                                end else begin
                                    pkt_err_r  <= 1'b1;
                                    err_code_r <= ERR_CSUM;
                                    state_r    <= ST_IDLE;
                                    busy_r     <= 1'b0;
                                end
                            end
                            default: begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end
                        endcase
                    end else if (to_cnt_r == TO_LAST) begin
                        pkt_err_r  <= 1'b1;
                        err_code_r <= ERR_TIMEOUT;
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_WIDTH'(1);
                    end
                end
                ST_COMMIT: begin
                    // Address/data only move on acceptance, so they hold while stalled.
                    if (wr_en_r && wr_rdy) begin
                        if (idx_r == last_r) begin
                            wr_en_r <= 1'b0;
                            state_r <= ST_DONE;
                        end else begin
                            idx_r     <= idx_nxt_s;
                            wr_addr_r <= base_r + 8'(idx_nxt_s);
                            wr_dat_r  <= buf_rd_dat_s;
                        end
                    end
                end
                ST_DONE: begin
                    pkt_done_r <= 1'b1;
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                end
                default: begin
                    wr_en_r <= 1'b0;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_dat   = wr_dat_r;
    assign pkt_done = pkt_done_r;
    assign pkt_err  = pkt_err_r;
    assign err_code = err_code_r;
    assign busy     = busy_r;

`ifdef PKT_STAT_EN
    logic [15:0] good_cnt_r;
    logic [15:0] bad_cnt_r;

    // Saturating packet statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_cnt_r <= 16'd0;
            bad_cnt_r  <= 16'd0;
        end else begin
            if (pkt_done_r && (good_cnt_r != 16'hFFFF)) begin
                good_cnt_r <= good_cnt_r + 16'd1;
            end
            if (pkt_err_r && (bad_cnt_r != 16'hFFFF)) begin
                bad_cnt_r <= bad_cnt_r + 16'd1;
            end
        end
    end

    assign good_cnt = good_cnt_r;
    assign bad_cnt  = bad_cnt_r;
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
module tb_uart_rx_pkt_ctrl;

    localparam int MAXL = 16;
    localparam int TO   = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_dat;
    logic       rx_rdy;
    logic       wr_rdy;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_dat;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;
`ifdef PKT_STAT_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
`endif

    always #5 clk = ~clk;

    uart_rx_pkt_ctrl #(
        .MAX_LEN(MAXL), .HDR_BYTE(8'hA5), .TIMEOUT_CYC(TO), .TO_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_rdy(rx_rdy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat), .wr_rdy(wr_rdy),
        .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code), .busy(busy)
`ifdef PKT_STAT_EN
        , .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    // monitor state
    int         cyc = 0;
    logic [7:0] wa_q[$];
    logic [7:0] wd_q[$];
    int         wc_q[$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [1:0] last_err = 2'd0;
    int         stab_viol = 0;
    logic       p_stall = 1'b0;
    logic [7:0] p_a = 8'd0;
    logic [7:0] p_d = 8'd0;

    // reference model state
    logic [7:0] pl[$];
    logic [7:0] fr[$];
    logic [7:0] ea[$];
    logic [7:0] ed[$];
    int d0, e0;

    // Observe accepted writes, pulses, and stability of a stalled request.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall && (!wr_en || wr_addr !== p_a || wr_dat !== p_d)) stab_viol++;
            if (wr_en && wr_rdy) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_dat);
                wc_q.push_back(cyc);
            end
            if (pkt_done) done_cnt++;
            if (pkt_err) begin
                err_cnt++;
                last_err = err_code;
            end
            p_stall = wr_en && !wr_rdy;
            p_a = wr_addr;
            p_d = wr_dat;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_dat = b;
        rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic fill_rand(input int len);
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    endtask

    // Frame and expected write list derived from the packet rules.
    task automatic make_frame(input logic [7:0] addr, input bit bad_csum);
        int s;
        logic [7:0] cs;
        fr.delete(); ea.delete(); ed.delete();
        s = int'(addr) + pl.size();
        fr.push_back(8'hA5); fr.push_back(addr); fr.push_back(8'(pl.size()));
        foreach (pl[i]) begin
            fr.push_back(pl[i]);
            s += int'(pl[i]);
            ea.push_back(8'(int'(addr) + i));
            ed.push_back(pl[i]);
        end
        cs = 8'(s % 256);
        if (bad_csum) begin
            cs = cs ^ 8'($urandom_range(1, 255));
            ea.delete(); ed.delete();
        end
        fr.push_back(cs);
    endtask

    task automatic send_frame(input int gap_max);
        foreach (fr[i]) send_byte(fr[i], (i == fr.size() - 1) ? 0 : $urandom_range(0, gap_max));
    endtask

    task automatic begin_pkt();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        d0 = done_cnt;
        e0 = err_cnt;
    endtask

    // mode 0: ready high, 1: random ready, 2: nst stall cycles per write
    task automatic run_commit(input int mode, input int nst);
        int stall = 0;
        for (int k = 0; k < 5000 && done_cnt == d0; k++) begin
            if (mode == 0) wr_rdy = 1'b1;
            else if (mode == 1) wr_rdy = 1'($urandom % 2);
            else if (wr_en && stall < nst) begin
                wr_rdy = 1'b0;
                stall++;
            end else begin
                wr_rdy = 1'b1;
                if (wr_en) stall = 0;
            end
            tick();
        end
        wr_rdy = 1'b1;
        tick();
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, wa_q.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa_q.size(); i++) begin
            check({tag, "_addr"}, wa_q[i], ea[i]);
            check({tag, "_data"}, wd_q[i], ed[i]);
        end
    endtask

    task automatic check_good(input string tag);
        check_writes(tag);
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_noerr"}, err_cnt - e0, 0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic check_drop(input string tag, input logic [1:0] code);
        check({tag, "_nwr"}, wa_q.size(), 0);
        check({tag, "_done"}, done_cnt - d0, 0);
        check({tag, "_err"}, err_cnt - e0, 1);
        check({tag, "_code"}, last_err, code);
        check({tag, "_errc_out"}, err_code, code);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int k;
        logic [7:0] b;
        rst = 1'b1; rx_rdy = 1'b0; rx_dat = 8'd0; wr_rdy = 1'b1;
        repeat (3) tick();
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_outs", {pkt_done, pkt_err, err_code, busy, wr_addr, wr_dat}, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);

        // good packet, ready high: consecutive writes, then done
        begin_pkt();
        pl = '{8'h11, 8'h22, 8'h33};
        make_frame(8'h10, 1'b0);
        send_frame(1);
        check("good_latency", wr_en, 1'b1);
        run_commit(0, 0);
        check_good("good");
        if (wc_q.size() == 3) check("good_consec", wc_q[2] - wc_q[0], 2);
        else check("good_consec_n", wc_q.size(), 3);

        // backpressure: 4 stall cycles per write
        begin_pkt();
        stab_viol = 0;
        send_frame(0);
        run_commit(2, 4);
        check_good("bp");
        check("bp_stable", stab_viol, 0);

        // bad checksum, then a good packet
        begin_pkt();
        pl = '{8'hAA, 8'hBB};
        make_frame(8'h10, 1'b0);
        fr[fr.size() - 1] = 8'h00;
        ea.delete(); ed.delete();
        send_frame(1);
        repeat (3) tick();
        check_drop("csum", 2'd2);
        begin_pkt();
        fill_rand(5);
        make_frame(8'h40, 1'b0);
        send_frame(2);
        run_commit(0, 0);
        check_good("after_csum");

        // bad lengths with trailing junk
        for (int t = 0; t < 2; t++) begin
            begin_pkt();
            send_byte(8'hA5, 0); send_byte(8'h10, 0);
            send_byte((t == 0) ? 8'h00 : 8'(MAXL + 1), 1);
            send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
            repeat (3) tick();
            check_drop((t == 0) ? "len0" : "lenmax1", 2'd1);
        end

        // maximum length packet
        begin_pkt();
        fill_rand(MAXL);
        make_frame(8'h80, 1'b0);
        send_frame(0);
        run_commit(0, 0);
        check_good("lenmax");

        // timeout mid-payload
        begin_pkt();
        send_byte(8'hA5, 0); send_byte(8'hFE, 0); send_byte(8'h03, 0); send_byte(8'h01, 0);
        k = 0;
        while (err_cnt == e0 && k < TO + 20) begin
            tick();
            k++;
        end
        check_drop("timeout", 2'd3);
        check("timeout_window", (k >= TO - 3) && (k <= TO + 3), 1'b1);

        // wrap of the write address
        begin_pkt();
        fill_rand(3);
        make_frame(8'hFE, 1'b0);
        send_frame(1);
        run_commit(0, 0);
        check_good("wrap");

        // a long stall in the commit phase must not time out
        begin_pkt();
        fill_rand(2);
        make_frame(8'h20, 1'b0);
        send_frame(0);
        run_commit(2, TO + 10);
        check_good("commit_stall");

        // reset during commit
        begin_pkt();
        fill_rand(4);
        make_frame(8'h30, 1'b0);
        wr_rdy = 1'b0;
        send_frame(0);
        repeat (3) tick();
        check("pre_rst_wr_en", wr_en, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_commit_wr_en", wr_en, 1'b0);
        check("rst_commit_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        wr_rdy = 1'b1;
        repeat (5) tick();
        check("rst_commit_done", done_cnt - d0, 0);
        check("rst_commit_err", err_cnt - e0, 0);
        check("rst_commit_nwr", wa_q.size(), 0);

        // leading garbage then a good packet
        begin_pkt();
        send_byte(8'h00, 0); send_byte(8'hFF, 1);
        fill_rand(3);
        make_frame(8'h55, 1'b0);
        send_frame(1);
        run_commit(0, 0);
        check_good("garbage");

        // randomized packets
        for (int n = 0; n < 20; n++) begin
            int kind, mode, len;
            logic [7:0] addr;
            kind = $urandom % 4;
            mode = $urandom % 3;
            addr = 8'($urandom);
            len = $urandom_range(1, MAXL);
            begin_pkt();
            if (kind == 3) begin
                send_byte(8'hA5, 0); send_byte(addr, 0);
                send_byte(($urandom % 2) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)), 0);
                for (int j = 0; j < 3; j++) begin
                    b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h5A;
                    send_byte(b, 0);
                end
                repeat (2) tick();
                check_drop("rnd_len", 2'd1);
            end else if (kind == 2) begin
                fill_rand(len);
                make_frame(addr, 1'b1);
                send_frame(2);
                repeat (3) tick();
                check_drop("rnd_csum", 2'd2);
            end else begin
                fill_rand(len);
                make_frame(addr, 1'b0);
                wr_rdy = 1'b1;
                send_frame(2);
                if (mode == 0) check("rnd_latency", wr_en, 1'b1);
                run_commit(mode, $urandom_range(0, 3));
                check_good("rnd_good");
                if (mode == 0 && wc_q.size() == len) check("rnd_consec", wc_q[len - 1] - wc_q[0], len - 1);
            end
            repeat (2) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
- Packet controller behind the UART receiver. It consumes the receiver's byte stream (rx_dat plus the single-cycle rx_rdy strobe) and frames bytes into packets.
- Each packet's payload is buffered and its checksum verified. Only then is the payload committed as a burst of register writes, with a ready handshake, to the local register bank.
- Malformed or stalled packets are dropped and flagged.

Parameters:
- MAX_LEN, 16, maximum payload bytes per packet (power of 2, 2..256).
- HDR_BYTE, 8'hA5, start-of-packet marker.
- TIMEOUT_CYC, 50000, clk cycles allowed between bytes inside a packet (1 ms at 50 MHz).
- TO_WIDTH, 16, width of the inter-byte timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- rx_dat  in  8  received byte; valid while rx_rdy=1.
- rx_rdy  in  1  one-cycle strobe, one received byte.
- wr_en  out  1  register write request; held until accepted.
- wr_addr  out  8  register address.
- wr_dat  out  8  register write data.
- wr_rdy  in  1  register bank accepts the write when wr_en & wr_rdy.
- pkt_done  out  1  one-cycle pulse: packet fully committed.
- pkt_err  out  1  one-cycle pulse: packet dropped.
- err_code  out  2  cause of last drop: 1=bad length, 2=checksum, 3=timeout; holds until next drop.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All outputs reset to 0, the FSM resets to IDLE and all counters clear.
- Frame format: HDR, ADDR, LEN, LEN payload bytes, CSUM.
  - CSUM = (ADDR + LEN + sum of payload) mod 256, computed with an 8-bit accumulator.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM, COMMIT, DONE.
  - IDLE: on rx_rdy with rx_dat==HDR_BYTE go to ADDR. Any other byte is ignored.
  - ADDR: latch base address; accumulator = rx_dat; go to LEN.
  - LEN: if rx_dat==0 or rx_dat>MAX_LEN, raise err 1 and return to IDLE. Otherwise latch len, idx=0, add the byte to the accumulator, go to DATA.
  - DATA: write rx_dat to buf[idx], add it to the accumulator, idx++. When idx reaches len-1 on a strobe, go to CSUM.
  - CSUM: if rx_dat==accumulator go to COMMIT with idx=0. Otherwise raise err 2 and go to IDLE.
  - COMMIT: drive wr_en=1, wr_addr=(base+idx) mod 256 (wraps), wr_dat=buf[idx]. On wr_en&wr_rdy, idx++. After the last accepted write, go to DONE.
  - DONE: pulse pkt_done for 1 cycle, then go to IDLE.
- Commit latency: the first wr_en is asserted the cycle after the CSUM byte strobe. With wr_rdy tied high, the burst takes exactly len cycles.
- While wr_en=1 and wr_rdy=0, wr_addr and wr_dat must remain stable.
- Timeout:
  - The counter runs in ADDR, LEN, DATA and CSUM and clears on every rx_rdy.
  - When it reaches TIMEOUT_CYC-1, raise err 3 and go to IDLE.
  - It does not run in COMMIT or DONE.
- rx_rdy during COMMIT or DONE: the byte is discarded. Header hunting resumes only in IDLE.
- Error reporting: a drop pulses pkt_err for 1 cycle, updates err_code, and returns the FSM to IDLE on the same edge.
- A HDR_BYTE value appearing in mid-packet is treated as data; there is no resync.
- Reset mid-packet or mid-commit aborts immediately. A partial burst is not resumed, and no pkt_err is raised.
- Payload buffer: MAX_LEN x 8 register array. It is written only in DATA; its contents are not cleared by reset.

Optional Feature:
- Macro: PKT_STAT_EN.
- Defined:
  - Adds outputs good_cnt[15:0] and bad_cnt[15:0].
  - good_cnt increments on pkt_done; bad_cnt increments on pkt_err.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package uart_pkt_pkg:
  - FSM state encoding.
  - err_code constants ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2, ERR_TIMEOUT=3.
  - Default HDR_BYTE.
- One natural sub-module: uart_pkt_buf, the MAX_LEN x 8 payload store.
  - Synchronous write port.
  - Asynchronous read port indexed by idx.

Test Plan:
- Good packet: A5 10 03 11 22 33 CSUM=0x79, wr_rdy=1 → writes (10,11),(11,22),(12,33) on 3 consecutive cycles, then a pkt_done pulse; pkt_err stays 0.
- Backpressure: same packet with wr_rdy low for 4 cycles on each write → wr_addr and wr_dat stable while stalled; exactly 3 accepted writes; then pkt_done.
- Bad checksum: A5 10 02 AA BB 00 → no wr_en; pkt_err pulse with err_code=2; a following good packet is committed normally.
- Bad length: LEN=0x00, then LEN=MAX_LEN+1 → err_code=1 for each; remaining bytes are ignored until the next A5.
- Timeout and wrap: A5 FE 03 01, then silence for TIMEOUT_CYC cycles → err_code=3, busy falls. A good packet at ADDR=FE with LEN=3 then writes addresses FE, FF, 00.
- Reset and garbage: rst asserted during COMMIT → wr_en=0 immediately, no pkt_done. Leading bytes 00 FF before A5 are ignored.
